// File: rtl/osd_event_pkg.sv
// Shared constants and width helpers for the OSD event path
// (packetizer and the arbiters that feed it).
package osd_event_pkg;

  localparam int         NUM_HEADER_FLITS  = 3;
  localparam logic [3:0] TYPE_SUB_LAST     = 4'h0;
  localparam logic [3:0] TYPE_SUB_CONTINUE = 4'h1;
  localparam logic [3:0] TYPE_SUB_OVERFLOW = 4'h5;

  typedef enum logic {
    ARB  = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Word-count width: must hold 0..max_words inclusive.
  function automatic int calc_w(input int max_words);
    return $clog2(max_words + 1);
  endfunction

  function automatic int calc_iw(input int max_words);
    return (max_words > 1) ? $clog2(max_words) : 1;
  endfunction

  function automatic int calc_gw(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

endpackage

// File: rtl/osd_rr_select.sv
// Combinational round-robin pick: first requester after 'last', wrapping.
module osd_rr_select
  import osd_event_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int GW      = calc_gw(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [GW-1:0]      last,
  output logic [GW-1:0]      sel,
  output logic               any
);

  logic [GW-1:0] idx;

  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = GW'((int'(last) + k) % NUM_SRC);
      if (!any && req[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/osd_event_arbiter.sv
// Shares one event packetizer between NUM_SRC sources; the grant is held
// for a whole event (all continuation packets) until the packetizer consumes it.
module osd_event_arbiter
  import osd_event_pkg::*;
#(
  parameter  int NUM_SRC            = 4,
  parameter  int MAX_DATA_NUM_WORDS = 8,
  localparam int W                  = calc_w(MAX_DATA_NUM_WORDS),
  localparam int IW                 = calc_iw(MAX_DATA_NUM_WORDS),
  localparam int GW                 = calc_gw(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SRC-1:0]    src_event_available,
  output logic [NUM_SRC-1:0]    src_event_consumed,
  input  logic [NUM_SRC-1:0]    src_overflow,
  input  logic [NUM_SRC*16-1:0] src_dest,
  input  logic [NUM_SRC*W-1:0]  src_data_num_words,
  input  logic [NUM_SRC*16-1:0] src_data,
  output logic [IW-1:0]         src_data_req_idx,
  output logic [NUM_SRC-1:0]    src_data_req_valid,
  output logic                  pkt_event_available,
  input  logic                  pkt_event_consumed,
  output logic                  pkt_overflow,
  output logic [15:0]           pkt_dest,
  output logic [W-1:0]          pkt_data_num_words,
  input  logic [IW-1:0]         pkt_data_req_idx,
  input  logic                  pkt_data_req_valid,
  output logic [15:0]           pkt_data,
  output logic [GW-1:0]         grant_idx,
  output logic                  zero_len_drop
);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_grant_q, last_grant_d;

  logic [GW-1:0] sel;
  logic          sel_any;

  logic [15:0]   dest_a  [NUM_SRC];
  logic [15:0]   data_a  [NUM_SRC];
  logic [W-1:0]  words_a [NUM_SRC];

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      dest_a[i]  = src_dest[16*i +: 16];
      data_a[i]  = src_data[16*i +: 16];
      words_a[i] = src_data_num_words[W*i +: W];
    end
  end

  osd_rr_select #(.NUM_SRC(NUM_SRC)) u_rr_select (
    .req  (src_event_available),
    .last (last_grant_q),
    .sel  (sel),
    .any  (sel_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_SRC - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    grant_d             = grant_q;
    last_grant_d        = last_grant_q;
    src_event_consumed  = '0;
    src_data_req_idx    = pkt_data_req_idx;
    src_data_req_valid  = '0;
    pkt_event_available = 1'b0;
    pkt_overflow        = 1'b0;
    pkt_dest            = '0;
    pkt_data_num_words  = '0;
    pkt_data            = '0;
    zero_len_drop       = 1'b0;

    unique case (state_q)
      ARB: begin
        if (sel_any) begin
          if (src_overflow[sel] || (words_a[sel] != '0)) begin
            grant_d = sel;
            state_d = BUSY;
          end else begin
            // Zero-word events would underflow the packetizer's length math,
            // so they are acknowledged here and never forwarded.
            src_event_consumed[sel] = 1'b1;
            zero_len_drop           = 1'b1;
            last_grant_d            = sel;
          end
        end
      end
      BUSY: begin
        pkt_event_available         = src_event_available[grant_q];
        pkt_overflow                = src_overflow[grant_q];
        pkt_dest                    = dest_a[grant_q];
        pkt_data_num_words          = words_a[grant_q];
        pkt_data                    = data_a[grant_q];
        src_data_req_valid[grant_q] = pkt_data_req_valid;
        if (pkt_event_consumed) begin
          src_event_consumed[grant_q] = 1'b1;
          last_grant_d                = grant_q;
          state_d                     = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign grant_idx = grant_q;

endmodule

// File: tb/tb_osd_event_arbiter.sv
// Scoreboard bench for osd_event_arbiter with a behavioural packetizer front end.
module tb_osd_event_arbiter;

  localparam int NUM_SRC = 4;
  localparam int MAXW    = 8;
  localparam int W       = 4;
  localparam int IW      = 3;
  localparam int GW      = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_SRC-1:0]    avail, ovf;
  logic [15:0]           dest [NUM_SRC];
  logic [15:0]           base [NUM_SRC];
  logic [W-1:0]          nw   [NUM_SRC];
  logic [NUM_SRC*16-1:0] src_dest_v, src_data_v;
  logic [NUM_SRC*W-1:0]  src_nw_v;

  logic [NUM_SRC-1:0] src_event_consumed, src_data_req_valid;
  logic [IW-1:0]      src_data_req_idx;
  logic               pkt_event_available, pkt_event_consumed, pkt_overflow;
  logic [15:0]        pkt_dest, pkt_data;
  logic [W-1:0]       pkt_data_num_words;
  logic [IW-1:0]      pkt_data_req_idx;
  logic               pkt_data_req_valid;
  logic [GW-1:0]      grant_idx;
  logic               zero_len_drop;

  // Sources answer the broadcast index combinationally with base+idx.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_dest_v[16*i +: 16] = dest[i];
      src_nw_v[W*i +: W]     = nw[i];
      src_data_v[16*i +: 16] = base[i] + 16'(src_data_req_idx);
    end
  end

  osd_event_arbiter #(.NUM_SRC(NUM_SRC), .MAX_DATA_NUM_WORDS(MAXW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .src_event_available (avail),
    .src_event_consumed  (src_event_consumed),
    .src_overflow        (ovf),
    .src_dest            (src_dest_v),
    .src_data_num_words  (src_nw_v),
    .src_data            (src_data_v),
    .src_data_req_idx    (src_data_req_idx),
    .src_data_req_valid  (src_data_req_valid),
    .pkt_event_available (pkt_event_available),
    .pkt_event_consumed  (pkt_event_consumed),
    .pkt_overflow        (pkt_overflow),
    .pkt_dest            (pkt_dest),
    .pkt_data_num_words  (pkt_data_num_words),
    .pkt_data_req_idx    (pkt_data_req_idx),
    .pkt_data_req_valid  (pkt_data_req_valid),
    .pkt_data            (pkt_data),
    .grant_idx           (grant_idx),
    .zero_len_drop       (zero_len_drop)
  );

  // A granted source must not withdraw its event before it is consumed.
  a_no_withdraw: assert property (@(posedge clk) disable iff (!rst)
    (pkt_event_available && !pkt_event_consumed) |=> pkt_event_available)
    else $error("source withdrew event while granted");

  typedef struct {
    int          src;
    logic [15:0] dest;
    logic [W-1:0] nw;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_src(input int i, input logic [15:0] d, input logic [15:0] b,
                         input logic [W-1:0] n, input logic o);
    dest[i]  = d;
    base[i]  = b;
    nw[i]    = n;
    ovf[i]   = o;
    avail[i] = 1'b1;
  endtask

  task automatic expect_src(input int i);
    exp_t e;
    e.src  = i;
    e.dest = dest[i];
    e.nw   = nw[i];
    e.ovf  = ovf[i];
    sb.push_back(e);
  endtask

  // Called just after a posedge; expects one ARB cycle then the grant.
  // abort_at >= 0 asserts reset while that payload word is being requested.
  task automatic run_event(input int abort_at);
    int   cyc;
    int   n;
    exp_t e;
    cyc = 0;
    @(negedge clk);
    chk("arb_bubble", 32'(pkt_event_available), 0);
    chk("arb_no_consumed", 32'(src_event_consumed), 0);
    while (!pkt_event_available && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("grant_latency", 32'(cyc), 1);
    chk("sb_nonempty", 32'(sb.size() > 0), 1);
    if (sb.size() == 0 || !pkt_event_available) return;
    e = sb.pop_front();
    chk("grant_idx", 32'(grant_idx), 32'(e.src));
    chk("pkt_dest", 32'(pkt_dest), 32'(e.dest));
    chk("pkt_num_words", 32'(pkt_data_num_words), 32'(e.nw));
    chk("pkt_overflow", 32'(pkt_overflow), 32'(e.ovf));
    n = e.ovf ? 1 : int'(e.nw);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      pkt_data_req_idx   = IW'(k);
      pkt_data_req_valid = 1'b1;
      if (k == abort_at) begin
        #2 rst = 1'b0;
        #1;
        chk("rst_pkt_avail", 32'(pkt_event_available), 0);
        chk("rst_grant_idx", 32'(grant_idx), 0);
        chk("rst_req_valid", 32'(src_data_req_valid), 0);
        chk("rst_pkt_dest", 32'(pkt_dest), 0);
        pkt_data_req_valid = 1'b0;
        return;
      end
      @(negedge clk);
      chk("req_valid", 32'(src_data_req_valid), 32'(1 << e.src));
      chk("pkt_data", 32'(pkt_data), 32'(base[e.src] + 16'(k)));
      chk("grant_lock", 32'(grant_idx), 32'(e.src));
    end
    @(posedge clk);
    #1;
    pkt_data_req_valid = 1'b0;
    pkt_event_consumed = 1'b1;
    @(negedge clk);
    chk("consumed", 32'(src_event_consumed), 32'(1 << e.src));
    @(posedge clk);
    #1;
    pkt_event_consumed = 1'b0;
    avail[e.src]       = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    avail = '0;
    ovf   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      dest[i] = '0;
      base[i] = '0;
      nw[i]   = '0;
    end
    pkt_event_consumed = 1'b0;
    pkt_data_req_idx   = '0;
    pkt_data_req_valid = 1'b0;

    #12;
    chk("reset_grant_idx", 32'(grant_idx), 0);
    chk("reset_pkt_avail", 32'(pkt_event_available), 0);
    chk("reset_consumed", 32'(src_event_consumed), 0);
    chk("reset_req_valid", 32'(src_data_req_valid), 0);
    chk("reset_zero_drop", 32'(zero_len_drop), 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Stray consumed pulse while idle must be ignored.
    pkt_event_consumed = 1'b1;
    @(negedge clk);
    chk("idle_consumed_ignored", 32'(src_event_consumed), 0);
    @(posedge clk);
    #1 pkt_event_consumed = 1'b0;

    // Single source, 5 words.
    set_src(0, 16'h0100, 16'hA000, 4'd5, 1'b0);
    expect_src(0);
    run_event(-1);

    // Simultaneous requests served 1, 2, 3.
    set_src(1, 16'h0101, 16'hB100, 4'd2, 1'b0);
    set_src(2, 16'h0102, 16'hB200, 4'd2, 1'b0);
    set_src(3, 16'h0103, 16'hB300, 4'd2, 1'b0);
    expect_src(1);
    expect_src(2);
    expect_src(3);
    repeat (3) run_event(-1);

    // Fairness: src0 re-requests at once with src2 pending; src2 goes first.
    set_src(0, 16'h0200, 16'hC000, 4'd1, 1'b0);
    expect_src(0);
    run_event(-1);
    set_src(0, 16'h0201, 16'hC100, 4'd3, 1'b0);
    set_src(2, 16'h0202, 16'hC200, 4'd2, 1'b0);
    expect_src(2);
    expect_src(0);
    repeat (2) run_event(-1);

    // Long event on src1 keeps the grant while src0 waits.
    set_src(1, 16'h0301, 16'hD100, 4'd8, 1'b0);
    set_src(0, 16'h0300, 16'hD000, 4'd2, 1'b0);
    expect_src(1);
    expect_src(0);
    repeat (2) run_event(-1);

    // Overflow event with zero words is forwarded.
    set_src(2, 16'h0402, 16'h0007, 4'd0, 1'b1);
    expect_src(2);
    run_event(-1);

    // Zero-length non-overflow event is dropped in the arbitration cycle.
    set_src(3, 16'h0403, 16'h0000, 4'd0, 1'b0);
    @(negedge clk);
    chk("zl_consumed", 32'(src_event_consumed), 32'h8);
    chk("zl_drop", 32'(zero_len_drop), 1);
    chk("zl_not_forwarded", 32'(pkt_event_available), 0);
    @(posedge clk);
    #1 avail[3] = 1'b0;
    @(negedge clk);
    chk("zl_drop_pulse", 32'(zero_len_drop), 0);
    chk("zl_still_idle", 32'(pkt_event_available), 0);
    @(posedge clk);
    #1;

    // Reset during src1's third payload word; src0 then wins first.
    set_src(1, 16'h0501, 16'hE100, 4'd5, 1'b0);
    expect_src(1);
    run_event(2);
    set_src(0, 16'h0500, 16'hE000, 4'd3, 1'b0);
    expect_src(0);
    expect_src(1);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) run_event(-1);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/osd_event_arbiter.md
Name: osd_event_arbiter

Overview:
- Shares one osd_event_packetization instance between NUM_SRC event sources, such as trace units or counters inside one debug module.
- Selects a source round-robin and locks the grant for the whole event, including all continuation packets, until the packetizer pulses event_consumed.
- Muxes the granted source's dest, overflow, word count and data into the packetizer, and routes the data-request and consumed handshakes back to that source.

Parameters:
- NUM_SRC, 4, number of event sources (1..16).
- MAX_DATA_NUM_WORDS, 8, maximum payload words per event, identical for all sources; must equal the packetizer's value.

Ports:
- Derived widths: W = $clog2(MAX_DATA_NUM_WORDS+1), IW = $clog2(MAX_DATA_NUM_WORDS), GW = max(1, $clog2(NUM_SRC)).
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; asynchronous, active-low.
- src_event_available  in  NUM_SRC  per-source event pending.
- src_event_consumed  out  NUM_SRC  per-source one-cycle pulse: event sent or dropped.
- src_overflow  in  NUM_SRC  per-source: the pending event is an overflow event.
- src_dest  in  NUM_SRC*16  per-source DI destination; source i at [16i+15:16i].
- src_data_num_words  in  NUM_SRC*W  per-source word count.
- src_data  in  NUM_SRC*16  per-source data word for the broadcast index.
- src_data_req_idx  out  IW  broadcast data-word index.
- src_data_req_valid  out  NUM_SRC  one-hot request valid; only the granted bit may be set.
- pkt_event_available  out  1  to packetizer event_available.
- pkt_event_consumed  in  1  from packetizer event_consumed.
- pkt_overflow  out  1  to packetizer overflow.
- pkt_dest  out  16  to packetizer dest.
- pkt_data_num_words  out  W  to packetizer data_num_words.
- pkt_data_req_idx  in  IW  from packetizer data_req_idx.
- pkt_data_req_valid  in  1  from packetizer data_req_valid.
- pkt_data  out  16  to packetizer data.
- grant_idx  out  GW  currently or last granted source (status).
- zero_len_drop  out  1  one-cycle pulse when a zero-word, non-overflow event is discarded.

Behaviour:
- Registers: state {ARB, BUSY}, grant (GW), last_grant (GW).
- Reset values: state=ARB, grant=0, last_grant=NUM_SRC-1, so source 0 has first priority.
- In ARB:
  - Every output is 0 except src_data_req_idx=pkt_data_req_idx (always a pass-through).
  - sel = first i with src_event_available[i]=1, scanning last_grant+1, last_grant+2, ... modulo NUM_SRC.
  - Normal request: sel exists and (src_overflow[sel]=1 or src_data_num_words[sel]!=0). Then grant<=sel and state<=BUSY, giving a one-cycle arbitration latency.
  - Zero-length request: sel exists, src_overflow[sel]=0 and src_data_num_words[sel]==0. This event is never forwarded, because the packetizer's num_words-1 arithmetic underflows.
    - Same cycle: src_event_consumed[sel]=1, zero_len_drop=1.
    - Next cycle: last_grant<=sel; state stays ARB.
  - No request: state stays ARB.
- In BUSY, all outputs are combinational muxes from grant:
  - pkt_event_available=src_event_available[grant].
  - pkt_overflow=src_overflow[grant].
  - pkt_dest=src_dest[grant].
  - pkt_data_num_words=src_data_num_words[grant].
  - pkt_data=src_data[grant].
  - src_data_req_valid[grant]=pkt_data_req_valid; all other bits 0.
- Exit from BUSY: when pkt_event_consumed=1, src_event_consumed[grant]=1 in the same cycle. Next cycle: last_grant<=grant, state<=ARB.
- Re-arbitration bubble:
  - Exactly one ARB cycle separates consecutive events.
  - The source just served has the lowest priority in that cycle.
- Grant lock:
  - The grant never changes in BUSY; requests from other sources only wait.
  - Continuation packets (TYPE_SUB 1) from the packetizer stay with the same source.
- Source contract:
  - src_event_available and src_overflow, src_dest, src_data_num_words must stay stable from grant until src_event_consumed.
  - Withdrawal while granted is a protocol violation. The arbiter holds the grant regardless; the bench flags it with an assertion.
- Edge cases:
  - pkt_event_consumed in ARB is ignored.
  - NUM_SRC=1 degenerates to a pass-through with the ARB bubble and the zero-length filter.
- grant_idx=grant at all times.
- Asynchronous reset mid-event returns to reset values immediately; the packetizer is reset by the same rst.

Decomposition:
- Package osd_event_pkg: localparams NUM_HEADER_FLITS=3, TYPE_SUB_LAST=4'h0, TYPE_SUB_CONTINUE=4'h1, TYPE_SUB_OVERFLOW=4'h5, and the W/IW width functions. These are shared with osd_event_packetization.
- One sub-module, osd_rr_select: combinational round-robin, taking req[NUM_SRC] and last[GW] and returning sel[GW] and any. It is reused by other OSD arbiters.

Test Plan:
- Single source: src0 available, 5 words -> grant_idx=0 one cycle after the request.
  - Packetizer emits one 8-flit packet with TYPE_SUB 0.
  - src_event_consumed[0] pulses once; src_data_req_valid[1..3]=0 throughout.
- Simultaneous requests after reset: src1, src2 and src3 all available, 2 words each -> served in order 1, 2, 3.
  - Exactly one ARB cycle between events.
  - pkt_dest follows each source's dest.
- Fairness: src0 re-requests immediately after being consumed, with src2 pending -> src2 is served before src0's second event.
- Long event: src1 with MAX_DATA_NUM_WORDS=20 and MAX_PKT_LEN=12 while src0 requests -> grant stays 1 across all 3 packets.
  - Packet TYPE_SUB sequence is 1, 1, 0.
  - src0 is granted only after the consumed pulse.
- Overflow plus zero-length:
  - src2 has overflow=1, num_words=0, data=16'h0007 -> forwarded as a 4-flit packet with TYPE_SUB 5 and payload 0x0007.
  - src3 has overflow=0, num_words=0 -> zero_len_drop=1 and src_event_consumed[3]=1 in the arbitration cycle, with no flits emitted.
- Reset mid-event: assert rst low during src1's third payload flit -> all outputs read 0 while rst is low; state returns to ARB.
  - After release, source 0 again has first priority.
